// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexes a 16-bit hex value onto a 4-digit display bus.
// Emits a digit code plus digit index, blanks leading zeros, latches new values
// through a shadow register so a frame never mixes old and new nibbles.
module seg_scan_driver #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [15:0] value,
   input  logic        load,
   output logic        ready,
   output logic [4:0]  data,
   output logic [1:0]  sel,
   output logic        frame_done
);

   localparam int unsigned    CntW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
   localparam logic [4:0]     Blank  = 5'd16;

   typedef enum logic {StIdle, StScan} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [4:0]       data_q, data_d;
   logic             fd_q, fd_d;
   logic [15:0]      active_q, active_d;
   logic [15:0]      shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic             tick, wrap, take_load;

   // Digit code for index k: the nibble, or blank when it and all higher nibbles are zero.
   function automatic logic [4:0] code_of(input logic [15:0] v, input logic [1:0] k);
      logic [15:0] upper;
      upper = v >> {k, 2'b00};
      if (BLANK_LZ && (k != 2'd0) && (upper == 16'h0000)) begin
         code_of = Blank;
      end else begin
         code_of = {1'b0, upper[3:0]};
      end
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state follows enable directly.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (enable) state_d = StScan;
         StScan: if (!enable) state_d = StIdle;
      endcase
   end

   // Datapath next-state: prescaler, digit index, digit code, update handshake.
   always_comb begin
      cnt_d     = cnt_q;
      sel_d     = sel_q;
      data_d    = data_q;
      fd_d      = 1'b0;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;

      tick      = (cnt_q == CntMax);
      wrap      = (state_q == StScan) && tick && (sel_q == 2'd3);
      take_load = load && !pending_q;

      if (take_load) begin
         shadow_d  = value;
         pending_d = 1'b1;
      end
      // Swap only at a frame boundary, or immediately when not scanning.
      if (pending_q && ((state_q == StIdle) || (wrap && (state_d == StScan)))) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end

      // Codes use active_d so the first digit of a new frame already shows the new value.
      unique case (state_d)
         StIdle: begin
            cnt_d  = '0;
            sel_d  = 2'd0;
            data_d = Blank;
         end
         StScan: begin
            if (state_q == StIdle) begin
               cnt_d  = '0;
               sel_d  = 2'd0;
               data_d = code_of(active_d, 2'd0);
            end else if (tick) begin
               cnt_d  = '0;
               sel_d  = sel_q + 2'd1;
               data_d = code_of(active_d, sel_q + 2'd1);
               fd_d   = (sel_q == 2'd3);
            end else begin
               cnt_d  = cnt_q + CntW'(1);
            end
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         sel_q     <= 2'd0;
         data_q    <= Blank;
         fd_q      <= 1'b0;
         active_q  <= 16'h0000;
         shadow_q  <= 16'h0000;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         data_q    <= data_d;
         fd_q      <= fd_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
      end
   end

   // Outputs are all registered; ready simply reflects the free shadow slot.
   always_comb begin
      ready      = !pending_q;
      data       = data_q;
      sel        = sel_q;
      frame_done = fd_q;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Upstream feeder for the multiplexed 7-segment display controller.
- Holds a 16-bit hex value (four nibbles) and time-multiplexes it as a digit code `data` plus digit index `sel`, stepping through digits 0-3 at a programmable refresh rate.
- Adds leading-zero blanking, a tear-free frame-boundary update handshake and a frame-done strobe.
- Blank is encoded as `data` = 16 (5'b10000); the downstream controller decodes any value ≥16 as all segments off.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; legal range ≥1; prescaler width = clog2(REFRESH_DIV), minimum 1.
- BLANK_LZ, 1, 1 = blank leading zero digits, 0 = show all four digits.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scan, 0 = idle/blank.
- value  in  16  new display value; nibble k is digit k (digit 0 = LSN).
- load  in  1  update request, accepted only when ready=1.
- ready  out  1  1 = can accept load.
- data  out  5  digit code to display controller: 0-15 hex, 16 = blank.
- sel  out  2  active digit index.
- frame_done  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset values (async, immediate): prescaler=0, sel=0, data=16, active=0, shadow=0, pending=0, ready=1, frame_done=0, state=IDLE.
- States:
  - IDLE: enable=0.
  - SCAN: enable=1.
  - IDLE→SCAN on the first edge with enable=1.
  - SCAN→IDLE on the first edge with enable=0.
- IDLE behaviour: prescaler held at 0; sel=0; data=16; frame_done=0.
- SCAN prescaler: counts 0..REFRESH_DIV-1; tick = (count==REFRESH_DIV-1); count wraps to 0 on tick. With REFRESH_DIV=1, tick is every cycle.
- On a tick edge, sel and data update on the same edge (registered, no skew):
  - sel ← sel+1 (mod 4).
  - data ← code(next sel).
- IDLE→SCAN entry edge: sel=0, data=code(0), prescaler=0. Each slot then lasts exactly REFRESH_DIV cycles.
- code(k):
  - nibble k of `active`, zero-extended to 5 bits.
  - If BLANK_LZ=1 and nibbles k..3 of `active` are all zero and k≠0, code = 16 instead.
  - Digit 0 is never blanked; active=0 shows "   0".
- frame_done: 1 for exactly the cycle following a tick taken with sel=3, i.e. the first cycle with sel=0 of the new frame.
- Update handshake:
  - A load with ready=1 captures value→shadow, sets pending=1 and drives ready=0 from the next cycle.
  - A load with ready=0 is ignored and shadow is unchanged.
  - In SCAN, a pending update is applied on the wrapping tick (sel 3→0): active←shadow and pending←0 on that edge, ready=1 the following cycle. Digit 0 of the new frame already shows the new value.
  - In IDLE, a pending update is applied on the next edge; ready returns to 1 one cycle after load.
  - A load coinciding with the wrap tick is captured but applied on the next wrap; `active` must never mix old and new nibbles within one frame.
- enable dropping mid-frame: next edge goes to IDLE (data=16, sel=0, prescaler=0). No frame_done. Any pending update is applied in IDLE per the rule above.
- enable toggling never loses a captured load.
- Reset mid-operation: all state returns to reset values immediately; a pending update is discarded.

Test Plan:
1. Reset, REFRESH_DIV=4, BLANK_LZ=1:
   - load value=16'h12A0 while IDLE, then enable=1.
   - Required: data/sel sequence (0,0),(10,1),(2,2),(1,3), each held 4 cycles, repeating.
   - frame_done pulses once per 16 cycles, in the cycle sel returns to 0.
2. Leading-zero blanking:
   - value=16'h0005 → data 5,16,16,16.
   - value=16'h0000 → 0,16,16,16.
   - value=16'h0000 with BLANK_LZ=0 → 0,0,0,0.
3. Tear-free update:
   - Scanning 16'h1111; load 16'h2222 while sel=1.
   - Required: ready=0 until the wrap; the remaining digits of the current frame show 1; the first sel=0 slot after the wrap shows 2; ready=1 one cycle after the wrap.
4. Load while ready=0:
   - Second load 16'h3333 during a pending update.
   - Required: ignored; the display shows only 16'h2222 afterwards.
5. enable dropped at sel=2, mid-slot:
   - Required: next cycle data=16, sel=0, no frame_done.
   - Re-enable: scan restarts at sel=0 with a full 4-cycle slot.
6. Async reset asserted mid-frame with pending=1:
   - Required: outputs go to data=16, sel=0, ready=1 without a clock edge.
   - After release plus enable: displays 0 (active=0), not the pending value.
